// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared definitions for the parking barrier-gate controller
//               and the occupancy counter it feeds: gate FSM state type,
//               default timing constants and lot capacity constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  // Barrier gate controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DENY    = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PASSING = 3'd3,
    ST_DONE    = 3'd4
  } gate_state_t;

  // Default sensor debounce length and open-barrier wait
  localparam int PARK_DEBOUNCE_CYCLES = 4;
  localparam int PARK_OPEN_TIMEOUT    = 20;

  // Lot capacity used by the downstream occupancy counter
  localparam int PARK_TOTAL_CAPACITY  = 700;
  localparam int PARK_GENERAL_MAX     = 500;

  // The barrier stays raised until the cycle after the passage pulse, so
  // DONE is still a raised state.
  function automatic logic gate_is_raised(input gate_state_t s);
    return (s == ST_OPEN) || (s == ST_PASSING) || (s == ST_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_debounce.sv
`default_nettype none
// ============================================================================
// Module      : parking_debounce
// Description : Two-flop synchronizer followed by a consecutive-sample
//               debouncer for one asynchronous lane sensor.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               raw    - asynchronous sensor level
//               level  - synchronized, debounced level (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module parking_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;

  // r_cnt holds how many consecutive samples have already disagreed with
  // r_level; the sample that would make it DEBOUNCE_CYCLES commits the new
  // level and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/parking_gate.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate
// Description : Single-lane barrier gate controller. Debounces the request
//               and pass sensors, checks vacancy on entry lanes, drives the
//               barrier and emits one registered event per completed passage.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               req_raw          - passage request sensor (async level)
//               req_is_uni       - requester is a university vehicle
//               pass_raw         - vehicle-under-barrier loop (async level)
//               uni_space_ok     - university vacancy flag from counter
//               gen_space_ok     - general vacancy flag from counter
//               barrier_open     - barrier actuator command
//               car_event        - one-cycle pulse per completed passage
//               car_is_uni       - uni flag of the last accepted request
//               deny             - one-cycle pulse on a rejected request
//               tailgate         - one-cycle pulse on unauthorized passage
//               busy             - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate
  import parking_pkg::*;
#(
  parameter bit EXIT_GATE       = 1'b0,
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = PARK_OPEN_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_raw,
  input  logic req_is_uni,
  input  logic pass_raw,
  input  logic uni_space_ok,
  input  logic gen_space_ok,
  output logic barrier_open,
  output logic car_event,
  output logic car_is_uni,
  output logic deny,
  output logic tailgate,
  output logic busy
);

  localparam int               c_tmr_w    = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(OPEN_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Sensor conditioning
  // --------------------------------------------------------------------------
  logic w_req_db;
  logic w_pass_db;
  logic r_req_prev;
  logic r_pass_prev;
  logic w_req_edge;
  logic w_pass_edge;

  parking_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_req_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (req_raw),
    .level (w_req_db)
  );

  parking_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pass_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (pass_raw),
    .level (w_pass_db)
  );

  // Previous-level registers update every cycle regardless of state, so an
  // edge seen while busy is consumed rather than replayed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_prev  <= 1'b0;
      r_pass_prev <= 1'b0;
    end else begin
      r_req_prev  <= w_req_db;
      r_pass_prev <= w_pass_db;
    end
  end

  assign w_req_edge  = w_req_db  & ~r_req_prev;
  assign w_pass_edge = w_pass_db & ~r_pass_prev;

  // Exit lanes never consult vacancy.
  logic w_space_ok;
  assign w_space_ok = EXIT_GATE ? 1'b1
                    : (req_is_uni ? uni_space_ok : gen_space_ok);

  // --------------------------------------------------------------------------
  // Gate FSM and open-wait timer
  // --------------------------------------------------------------------------
  gate_state_t        r_state;
  gate_state_t        w_state_next;
  logic [c_tmr_w-1:0] r_timer;
  logic [c_tmr_w-1:0] w_timer_next;
  logic               w_accept;
  logic               w_tailgate_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_accept        = 1'b0;
    w_tailgate_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_edge) begin
          if (w_space_ok) begin
            w_accept     = 1'b1;
            w_timer_next = '0;
            w_state_next = ST_OPEN;
          end else begin
            w_state_next = ST_DENY;
          end
        end else if (w_pass_edge) begin
          w_tailgate_next = 1'b1;
        end
      end
      ST_DENY: begin
        w_state_next = ST_IDLE;
      end
      ST_OPEN: begin
        // A vehicle arriving on the last waiting cycle still wins over the
        // timeout.
        if (w_pass_db) begin
          w_state_next = ST_PASSING;
        end else if (r_timer == c_tmr_last) begin
          w_state_next = ST_IDLE;
        end else begin
          w_timer_next = r_timer + c_tmr_w'(1);
        end
      end
      ST_PASSING: begin
        if (!w_pass_db) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so each output lines up
  // with the state it describes and is free of decode glitches.
  // --------------------------------------------------------------------------
  logic r_barrier_open;
  logic r_car_event;
  logic r_car_is_uni;
  logic r_deny;
  logic r_tailgate;
  logic r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_barrier_open <= 1'b0;
      r_car_event    <= 1'b0;
      r_car_is_uni   <= 1'b0;
      r_deny         <= 1'b0;
      r_tailgate     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_barrier_open <= gate_is_raised(w_state_next);
      r_car_event    <= (w_state_next == ST_DONE);
      r_deny         <= (w_state_next == ST_DENY);
      r_tailgate     <= w_tailgate_next;
      r_busy         <= (w_state_next != ST_IDLE);
      // Held until the next accepted request so it stays valid around the
      // passage pulse.
      if (w_accept) begin
        r_car_is_uni <= req_is_uni;
      end
    end
  end

  assign barrier_open = r_barrier_open;
  assign car_event    = r_car_event;
  assign car_is_uni   = r_car_is_uni;
  assign deny         = r_deny;
  assign tailgate     = r_tailgate;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate
// Description : Self-checking bench for parking_gate. An entry-lane and an
//               exit-lane instance share the same stimulus; a behavioural
//               model predicts both every cycle, and directed checks pin
//               the key latencies and pulse counts.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate;

  localparam int DB = 4;
  localparam int TO = 20;

  logic clk;
  logic rst_n;
  logic req_raw;
  logic req_is_uni;
  logic pass_raw;
  logic uni_ok;
  logic gen_ok;

  logic [1:0] bo, ce, ciu, dn, tg, bz;

  parking_gate #(.EXIT_GATE(1'b0), .DEBOUNCE_CYCLES(DB), .OPEN_TIMEOUT(TO)) u_entry (
    .clk(clk), .rst_n(rst_n), .req_raw(req_raw), .req_is_uni(req_is_uni),
    .pass_raw(pass_raw), .uni_space_ok(uni_ok), .gen_space_ok(gen_ok),
    .barrier_open(bo[0]), .car_event(ce[0]), .car_is_uni(ciu[0]),
    .deny(dn[0]), .tailgate(tg[0]), .busy(bz[0])
  );

  parking_gate #(.EXIT_GATE(1'b1), .DEBOUNCE_CYCLES(DB), .OPEN_TIMEOUT(TO)) u_exit (
    .clk(clk), .rst_n(rst_n), .req_raw(req_raw), .req_is_uni(req_is_uni),
    .pass_raw(pass_raw), .uni_space_ok(uni_ok), .gen_space_ok(gen_ok),
    .barrier_open(bo[1]), .car_event(ce[1]), .car_is_uni(ciu[1]),
    .deny(dn[1]), .tailgate(tg[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse / level cycle counters observed on the DUTs
  int cnt_ce[2] = '{0, 0};
  int cnt_dn[2] = '{0, 0};
  int cnt_tg[2] = '{0, 0};
  int cnt_bo[2] = '{0, 0};

  // ---------------------------------------------------------------- model
  // Sensor view: raw is seen two edges late; a level is accepted once the
  // last DB seen samples all disagree with the current level.
  bit req_pipe[$], pass_pipe[$];
  bit req_win[$],  pass_win[$];
  bit req_lvl, req_lvl_prev, pass_lvl, pass_lvl_prev;

  // Gate view per lane: raised barrier, car under it, finishing passage,
  // denial in progress, cycles already waited.
  bit gate_up[2], car_under[2], finishing[2], denying[2], uni_flag[2];
  bit tail_now[2];
  int open_age[2];

  function automatic bit settle(input bit lvl, input bit win[$]);
    if (win.size() < DB) return lvl;
    foreach (win[i]) if (win[i] == lvl) return lvl;
    return !lvl;
  endfunction

  task automatic model_reset();
    req_pipe = '{1'b0, 1'b0};
    pass_pipe = '{1'b0, 1'b0};
    req_win.delete();
    pass_win.delete();
    req_lvl = 0; req_lvl_prev = 0; pass_lvl = 0; pass_lvl_prev = 0;
    for (int g = 0; g < 2; g++) begin
      gate_up[g] = 0; car_under[g] = 0; finishing[g] = 0; denying[g] = 0;
      uni_flag[g] = 0; tail_now[g] = 0; open_age[g] = 0;
    end
  endtask

  task automatic gate_step(input int g, input bit req_rise, input bit pass_rise);
    bit ok;
    tail_now[g] = 0;
    if (finishing[g]) begin
      finishing[g] = 0;
      gate_up[g]   = 0;
    end else if (denying[g]) begin
      denying[g] = 0;
    end else if (!gate_up[g]) begin
      if (req_rise) begin
        ok = (g == 1) || (req_is_uni ? uni_ok : gen_ok);
        if (ok) begin
          gate_up[g]  = 1;
          open_age[g] = 0;
          uni_flag[g] = req_is_uni;
        end else begin
          denying[g] = 1;
        end
      end else if (pass_rise) begin
        tail_now[g] = 1;
      end
    end else if (!car_under[g]) begin
      if (pass_lvl)                 car_under[g] = 1;
      else if (open_age[g] == TO-1) gate_up[g]   = 0;
      else                          open_age[g]++;
    end else if (!pass_lvl) begin
      car_under[g] = 0;
      finishing[g] = 1;
    end
  endtask

  task automatic model_step();
    bit rr, pr, s;
    rr = req_lvl && !req_lvl_prev;
    pr = pass_lvl && !pass_lvl_prev;
    for (int g = 0; g < 2; g++) gate_step(g, rr, pr);
    req_lvl_prev  = req_lvl;
    pass_lvl_prev = pass_lvl;
    req_pipe.push_back(req_raw);
    s = req_pipe.pop_front();
    req_win.push_back(s);
    if (req_win.size() > DB) void'(req_win.pop_front());
    req_lvl = settle(req_lvl, req_win);
    pass_pipe.push_back(pass_raw);
    s = pass_pipe.pop_front();
    pass_win.push_back(s);
    if (pass_win.size() > DB) void'(pass_win.pop_front());
    pass_lvl = settle(pass_lvl, pass_win);
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("lane%0d barrier_open", g), bo[g],  gate_up[g]);
      chk($sformatf("lane%0d car_event", g),    ce[g],  finishing[g]);
      chk($sformatf("lane%0d car_is_uni", g),   ciu[g], uni_flag[g]);
      chk($sformatf("lane%0d deny", g),         dn[g],  denying[g]);
      chk($sformatf("lane%0d tailgate", g),     tg[g],  tail_now[g]);
      chk($sformatf("lane%0d busy", g),         bz[g],  gate_up[g] | denying[g]);
      cnt_ce[g] += int'(ce[g]);
      cnt_dn[g] += int'(dn[g]);
      cnt_tg[g] += int'(tg[g]);
      cnt_bo[g] += int'(bo[g]);
    end
  endtask

  // One clock cycle: compare mid-cycle, advance model on the edge, then
  // leave the caller 1 time unit after the edge to drive new inputs.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise req for 10 cycles; return cycle index at which lane g barrier rose.
  task automatic request(input int g, output int first_open);
    first_open = -1;
    req_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bo[g] && first_open < 0) first_open = i;
    end
    req_raw = 1'b0;
  endtask

  task automatic pass_pulse(input int n);
    pass_raw = 1'b1;
    ticks(n);
    pass_raw = 1'b0;
  endtask

  int b_ce[2], b_dn[2], b_tg[2], b_bo[2];
  task automatic snap();
    for (int g = 0; g < 2; g++) begin
      b_ce[g] = cnt_ce[g]; b_dn[g] = cnt_dn[g];
      b_tg[g] = cnt_tg[g]; b_bo[g] = cnt_bo[g];
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  int lat;

  initial begin
    rst_n = 1'b0; req_raw = 0; req_is_uni = 0; pass_raw = 0; uni_ok = 0; gen_ok = 0;
    model_reset();
    ticks(3);
    chk("reset barrier_open", bo, 2'b00);
    chk("reset busy", bz, 2'b00);
    chk("reset pulses", {ce, dn, tg, ciu}, 8'h00);
    rst_n = 1'b1;
    ticks(3);

    // Entry, uni vehicle with uni space
    snap();
    uni_ok = 1; gen_ok = 0; req_is_uni = 1;
    request(0, lat);
    chk("uni open latency", lat, 7);
    pass_pulse(8);
    ticks(12);
    chk("uni car_event count", cnt_ce[0] - b_ce[0], 1);
    chk("uni car_is_uni", ciu[0], 1);
    chk("uni closed", bo[0], 0);
    chk("uni idle", bz[0], 0);

    // Entry, general vehicle, no general space
    snap();
    uni_ok = 1; gen_ok = 0; req_is_uni = 0;
    request(0, lat);
    ticks(30);
    chk("deny count", cnt_dn[0] - b_dn[0], 1);
    chk("deny barrier cycles", cnt_bo[0] - b_bo[0], 0);
    chk("deny car_event count", cnt_ce[0] - b_ce[0], 0);

    // Timeout: accepted, nobody passes
    snap();
    gen_ok = 1;
    request(0, lat);
    ticks(40);
    chk("timeout barrier cycles", cnt_bo[0] - b_bo[0], TO);
    chk("timeout car_event count", cnt_ce[0] - b_ce[0], 0);
    chk("timeout idle", bz[0], 0);

    // Glitch rejection: 3-cycle pulses
    snap();
    req_raw = 1; ticks(3); req_raw = 0; ticks(10);
    pass_raw = 1; ticks(3); pass_raw = 0; ticks(10);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("glitch lane%0d activity", g),
          (cnt_ce[g] - b_ce[g]) + (cnt_dn[g] - b_dn[g]) +
          (cnt_tg[g] - b_tg[g]) + (cnt_bo[g] - b_bo[g]), 0);
    end

    // Second request while the car is under the barrier
    snap();
    req_is_uni = 1;
    request(0, lat);
    ticks(2);
    pass_raw = 1;
    ticks(8);
    req_raw = 1; ticks(8); req_raw = 0;
    ticks(4);
    pass_raw = 0;
    ticks(15);
    chk("second req entry car_event", cnt_ce[0] - b_ce[0], 1);
    chk("second req exit car_event", cnt_ce[1] - b_ce[1], 1);
    chk("second req no deny", cnt_dn[0] - b_dn[0], 0);

    // Exit lane ignores vacancy
    snap();
    uni_ok = 0; gen_ok = 0; req_is_uni = 0;
    request(1, lat);
    chk("exit open latency", lat, 7);
    pass_pulse(8);
    ticks(12);
    chk("exit car_event count", cnt_ce[1] - b_ce[1], 1);
    chk("entry denied same request", cnt_dn[0] - b_dn[0], 1);

    // Tailgate in idle
    snap();
    pass_pulse(8);
    ticks(12);
    chk("tailgate exit count", cnt_tg[1] - b_tg[1], 1);
    chk("tailgate entry count", cnt_tg[0] - b_tg[0], 1);
    chk("tailgate no event", cnt_ce[1] - b_ce[1], 0);
    chk("tailgate no barrier", cnt_bo[1] - b_bo[1], 0);

    // Asynchronous reset while PASSING
    snap();
    uni_ok = 1; req_is_uni = 1;
    request(0, lat);
    pass_raw = 1;
    ticks(8);
    chk("pre-reset barrier up", bo[0], 1);
    rst_n = 1'b0;
    pass_raw = 0;
    model_reset();
    #1;
    chk("async reset barrier", bo, 2'b00);
    chk("async reset car_is_uni", ciu[0], 0);
    ticks(3);
    rst_n = 1'b1;
    ticks(15);
    chk("post-reset car_event", cnt_ce[0] - b_ce[0], 0);
    chk("post-reset idle", bz[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
